ahblite_arb2: RTL and testbench

AHBLITE_ARB2 -- requirements
Module: ahblite_arb2

---
 rtl/ahb_pkg.sv | 27 ++
 rtl/ahblite_arb2_hold.sv | 50 +++++
 rtl/ahblite_arb2.sv | 132 +++++++++++++
 tb/tb_ahblite_arb2.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and bundle types.
// Used by the two-master arbiter and its per-master capture logic.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  typedef struct packed {
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
  } ahb_ctl_t;

  function automatic logic trans_active(input logic [1:0] t);
    return t[1];
  endfunction

endpackage

// File: rtl/ahblite_arb2_hold.sv
// Per-master request capture: live request detect plus one pending entry.
// Ports: master addr/ctl in, master HREADY in, gnt in; req/addr/ctl/pend out.
module ahblite_arb2_hold
  import ahb_pkg::*;
#(
  parameter int AW = 24
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic          hready,
  input  logic          gnt,
  output logic          req,
  output logic [AW-1:0] req_addr,
  output ahb_ctl_t      req_ctl,
  output logic          pend
);

  logic          live;
  ahb_ctl_t      live_ctl;
  ahb_ctl_t      pend_ctl;
  logic [AW-1:0] pend_addr;

  assign live     = hsel & trans_active(htrans) & hready;
  assign live_ctl = '{trans: htrans, write: hwrite, size: hsize};

  // A captured entry always takes precedence over the live bus.
  assign req      = pend | live;
  assign req_addr = pend ? pend_addr : haddr;
  assign req_ctl  = pend ? pend_ctl : live_ctl;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_ctl  <= '0;
    end else if (gnt) begin
      pend      <= 1'b0;
    end else if (live && !pend) begin
      pend      <= 1'b1;
      pend_addr <= haddr;
      pend_ctl  <= live_ctl;
    end
  end

endmodule

// File: rtl/ahblite_arb2.sv
// Two-master AHB-lite arbiter onto one slave port, RR or fixed priority.
// Ports: M0_/M1_ master request in + response out; S_ slave request out + response in.
module ahblite_arb2
  import ahb_pkg::*;
#(
  parameter int AW = 24,
  parameter bit RR = 1'b1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          M0_HSEL,
  input  logic [AW-1:0] M0_HADDR,
  input  logic [1:0]    M0_HTRANS,
  input  logic          M0_HWRITE,
  input  logic [2:0]    M0_HSIZE,
  input  logic [31:0]   M0_HWDATA,
  output logic [31:0]   M0_HRDATA,
  output logic          M0_HREADY,
  output logic [1:0]    M0_HRESP,
  input  logic          M1_HSEL,
  input  logic [AW-1:0] M1_HADDR,
  input  logic [1:0]    M1_HTRANS,
  input  logic          M1_HWRITE,
  input  logic [2:0]    M1_HSIZE,
  input  logic [31:0]   M1_HWDATA,
  output logic [31:0]   M1_HRDATA,
  output logic          M1_HREADY,
  output logic [1:0]    M1_HRESP,
  output logic          S_HSEL,
  output logic [AW-1:0] S_HADDR,
  output logic [1:0]    S_HTRANS,
  output logic          S_HWRITE,
  output logic [2:0]    S_HSIZE,
  output logic [31:0]   S_HWDATA,
  output logic          S_HREADY,
  input  logic [31:0]   S_HRDATA,
  input  logic          S_HREADYOUT,
  input  logic [1:0]    S_HRESP
);

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic [1:0]    pend;
  logic [AW-1:0] addr0, addr1;
  ahb_ctl_t      ctl0, ctl1;
  logic          any, g1;
  logic [AW-1:0] sel_addr;
  ahb_ctl_t      sel_ctl;
  logic          own0, own1;
  logic          dp_valid, dp_owner;
  logic          last_gnt;
  logic [AW-1:0] last_addr;
  logic          last_write;
  logic [2:0]    last_size;

  ahblite_arb2_hold #(.AW(AW)) u_hold0 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .hsel(M0_HSEL), .haddr(M0_HADDR), .htrans(M0_HTRANS),
    .hwrite(M0_HWRITE), .hsize(M0_HSIZE),
    .hready(M0_HREADY), .gnt(gnt[0]),
    .req(req[0]), .req_addr(addr0), .req_ctl(ctl0), .pend(pend[0])
  );

  ahblite_arb2_hold #(.AW(AW)) u_hold1 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .hsel(M1_HSEL), .haddr(M1_HADDR), .htrans(M1_HTRANS),
    .hwrite(M1_HWRITE), .hsize(M1_HSIZE),
    .hready(M1_HREADY), .gnt(gnt[1]),
    .req(req[1]), .req_addr(addr1), .req_ctl(ctl1), .pend(pend[1])
  );

  // Grants only on a slave address-phase boundary; reset gates the
  // grant so the slave port sees IDLE immediately.
  always_comb begin
    gnt = 2'b00;
    if (HRESETn && S_HREADYOUT) begin
      unique case (req)
        2'b11:   gnt = (RR && !last_gnt) ? 2'b10 : 2'b01;
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign any      = |gnt;
  assign g1       = gnt[1];
  assign sel_addr = g1 ? addr1 : addr0;
  assign sel_ctl  = g1 ? ctl1 : ctl0;

  assign S_HSEL   = any;
  assign S_HTRANS = any ? sel_ctl.trans : HTRANS_IDLE;
  assign S_HADDR  = any ? sel_addr : last_addr;
  assign S_HWRITE = any ? sel_ctl.write : last_write;
  assign S_HSIZE  = any ? sel_ctl.size : last_size;
  assign S_HWDATA = dp_owner ? M1_HWDATA : M0_HWDATA;
  assign S_HREADY = S_HREADYOUT;

  assign own0 = dp_valid & ~dp_owner;
  assign own1 = dp_valid & dp_owner;

  // A non-owner is held off only while it has a captured entry.
  assign M0_HREADY = own0 ? S_HREADYOUT : ~pend[0];
  assign M1_HREADY = own1 ? S_HREADYOUT : ~pend[1];
  assign M0_HRESP  = own0 ? S_HRESP : HRESP_OKAY;
  assign M1_HRESP  = own1 ? S_HRESP : HRESP_OKAY;
  assign M0_HRDATA = own0 ? S_HRDATA : 32'h0;
  assign M1_HRDATA = own1 ? S_HRDATA : 32'h0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid   <= 1'b0;
      dp_owner   <= 1'b0;
      last_gnt   <= 1'b1;
      last_addr  <= '0;
      last_write <= 1'b0;
      last_size  <= 3'd0;
    end else begin
      if (S_HREADYOUT) begin
        dp_valid <= any;
        if (any) dp_owner <= g1;
      end
      if (any) begin
        last_gnt   <= g1;
        last_addr  <= sel_addr;
        last_write <= sel_ctl.write;
        last_size  <= sel_ctl.size;
      end
    end
  end

endmodule

// File: tb/tb_ahblite_arb2.sv
// Directed bench for ahblite_arb2: RR instance plus fixed-priority instance.
// Both share master/slave stimulus; a small slave logger records accepted transfers.
module tb_ahblite_arb2;
  import ahb_pkg::*;

  localparam int AW = 24;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b1;

  logic          m0_hsel, m1_hsel;
  logic [AW-1:0] m0_haddr, m1_haddr;
  logic [1:0]    m0_htrans, m1_htrans;
  logic          m0_hwrite, m1_hwrite;
  logic [2:0]    m0_hsize, m1_hsize;
  logic [31:0]   m0_hwdata, m1_hwdata;
  logic [31:0]   s_hrdata;
  logic          s_hreadyout;
  logic [1:0]    s_hresp;

  logic [31:0]   m0_hrdata, m1_hrdata;
  logic          m0_hready, m1_hready;
  logic [1:0]    m0_hresp, m1_hresp;
  logic          s_hsel, s_hwrite, s_hready;
  logic [AW-1:0] s_haddr;
  logic [1:0]    s_htrans;
  logic [2:0]    s_hsize;
  logic [31:0]   s_hwdata;

  logic [31:0]   f_m0_hrdata, f_m1_hrdata;
  logic          f_m0_hready, f_m1_hready;
  logic [1:0]    f_m0_hresp, f_m1_hresp;
  logic          f_s_hsel, f_s_hwrite, f_s_hready;
  logic [AW-1:0] f_s_haddr;
  logic [1:0]    f_s_htrans;
  logic [2:0]    f_s_hsize;
  logic [31:0]   f_s_hwdata;

  always #5 HCLK = ~HCLK;

  ahblite_arb2 #(.AW(AW), .RR(1'b1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HSEL(m0_hsel), .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans),
    .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize), .M0_HWDATA(m0_hwdata),
    .M0_HRDATA(m0_hrdata), .M0_HREADY(m0_hready), .M0_HRESP(m0_hresp),
    .M1_HSEL(m1_hsel), .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans),
    .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize), .M1_HWDATA(m1_hwdata),
    .M1_HRDATA(m1_hrdata), .M1_HREADY(m1_hready), .M1_HRESP(m1_hresp),
    .S_HSEL(s_hsel), .S_HADDR(s_haddr), .S_HTRANS(s_htrans),
    .S_HWRITE(s_hwrite), .S_HSIZE(s_hsize), .S_HWDATA(s_hwdata),
    .S_HREADY(s_hready), .S_HRDATA(s_hrdata),
    .S_HREADYOUT(s_hreadyout), .S_HRESP(s_hresp)
  );

  ahblite_arb2 #(.AW(AW), .RR(1'b0)) dut_fp (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HSEL(m0_hsel), .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans),
    .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize), .M0_HWDATA(m0_hwdata),
    .M0_HRDATA(f_m0_hrdata), .M0_HREADY(f_m0_hready), .M0_HRESP(f_m0_hresp),
    .M1_HSEL(m1_hsel), .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans),
    .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize), .M1_HWDATA(m1_hwdata),
    .M1_HRDATA(f_m1_hrdata), .M1_HREADY(f_m1_hready), .M1_HRESP(f_m1_hresp),
    .S_HSEL(f_s_hsel), .S_HADDR(f_s_haddr), .S_HTRANS(f_s_htrans),
    .S_HWRITE(f_s_hwrite), .S_HSIZE(f_s_hsize), .S_HWDATA(f_s_hwdata),
    .S_HREADY(f_s_hready), .S_HRDATA(s_hrdata),
    .S_HREADYOUT(s_hreadyout), .S_HRESP(s_hresp)
  );

  // Slave-side logger for the RR instance.
  logic        sl_dp = 1'b0;
  logic        sl_wr = 1'b0;
  logic [31:0] sl_wdata = 32'h0;
  int          n_xfer = 0;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sl_dp <= 1'b0;
      sl_wr <= 1'b0;
    end else if (s_hready) begin
      if (sl_dp && sl_wr) sl_wdata <= s_hwdata;
      sl_dp <= s_hsel && s_htrans[1];
      sl_wr <= s_hwrite;
      if (s_hsel && s_htrans[1]) n_xfer <= n_xfer + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_m0(input logic sel, input logic [AW-1:0] a,
                        input logic [1:0] tr, input logic wr);
    m0_hsel = sel; m0_haddr = a; m0_htrans = tr;
    m0_hwrite = wr; m0_hsize = 3'd2;
  endtask

  task automatic set_m1(input logic sel, input logic [AW-1:0] a,
                        input logic [1:0] tr, input logic wr);
    m1_hsel = sel; m1_haddr = a; m1_htrans = tr;
    m1_hwrite = wr; m1_hsize = 3'd2;
  endtask

  task automatic idle_all;
    set_m0(1'b0, '0, HTRANS_IDLE, 1'b0);
    set_m1(1'b0, '0, HTRANS_IDLE, 1'b0);
  endtask

  task automatic do_reset;
    idle_all();
    s_hreadyout = 1'b1;
    s_hresp = HRESP_OKAY;
    HRESETn = 1'b0;
    nxt();
    HRESETn = 1'b1;
    nxt();
  endtask

  int snap;

  initial begin
    idle_all();
    m0_hwdata = 32'h0; m1_hwdata = 32'h0;
    s_hrdata = 32'h0; s_hreadyout = 1'b1; s_hresp = HRESP_OKAY;
    #1 HRESETn = 1'b0;
    #1;
    check("rst_shsel", 32'(s_hsel), 32'h0);
    check("rst_shtrans", 32'(s_htrans), 32'h0);
    check("rst_shaddr", 32'(s_haddr), 32'h0);
    check("rst_m0rdy", 32'(m0_hready), 32'h1);
    check("rst_m1rdy", 32'(m1_hready), 32'h1);
    check("rst_m0resp", 32'(m0_hresp), 32'h0);
    check("rst_m1rdata", m1_hrdata, 32'h0);
    set_m0(1'b1, 24'h123, HTRANS_NONSEQ, 1'b1);
    #1;
    check("rst_gate_hsel", 32'(s_hsel), 32'h0);
    check("rst_gate_haddr", 32'(s_haddr), 32'h0);
    idle_all();
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    nxt();

    // M0 alone, zero-wait write of 0xA to 0x000000
    set_m0(1'b1, 24'h0, HTRANS_NONSEQ, 1'b1);
    #1;
    check("t1_hsel", 32'(s_hsel), 32'h1);
    check("t1_htrans", 32'(s_htrans), 32'h2);
    check("t1_hwrite", 32'(s_hwrite), 32'h1);
    check("t1_m0rdy_a", 32'(m0_hready), 32'h1);
    nxt();
    set_m0(1'b0, 24'h0, HTRANS_IDLE, 1'b0);
    m0_hwdata = 32'hA;
    #1;
    check("t1_hwdata", s_hwdata, 32'hA);
    check("t1_m0rdy_d", 32'(m0_hready), 32'h1);
    check("t1_idle", 32'(s_htrans), 32'h0);
    nxt();
    check("t1_latched", sl_wdata, 32'hA);

    // Simultaneous first requests after reset
    do_reset();
    set_m0(1'b1, 24'h10, HTRANS_NONSEQ, 1'b0);
    set_m1(1'b1, 24'h20, HTRANS_NONSEQ, 1'b0);
    #1;
    check("t2_first", 32'(s_haddr), 32'h10);
    check("t2_m1rdy0", 32'(m1_hready), 32'h1);
    nxt();
    idle_all();
    s_hrdata = 32'h11111111;
    #1;
    check("t2_m1rdy1", 32'(m1_hready), 32'h0);
    check("t2_second", 32'(s_haddr), 32'h20);
    check("t2_hsel", 32'(s_hsel), 32'h1);
    check("t2_m0rdata", m0_hrdata, 32'h11111111);
    nxt();
    s_hrdata = 32'h22222222;
    #1;
    check("t2_m1rdata", m1_hrdata, 32'h22222222);
    check("t2_m1rdy2", 32'(m1_hready), 32'h1);
    check("t2_m0rdata0", m0_hrdata, 32'h0);
    check("t2_hsel_off", 32'(s_hsel), 32'h0);
    nxt();

    // Continuous contention: RR alternates, fixed priority starves M1
    do_reset();
    set_m0(1'b1, 24'h100, HTRANS_NONSEQ, 1'b0);
    set_m1(1'b1, 24'h200, HTRANS_NONSEQ, 1'b0);
    for (int k = 0; k < 8; k++) begin
      #1;
      check("t3_rr_addr", 32'(s_haddr), (k % 2) ? 32'h200 : 32'h100);
      check("t3_fp_addr", 32'(f_s_haddr), 32'h100);
      check("t3_fp_m1rdy", 32'(f_m1_hready), (k == 0) ? 32'h1 : 32'h0);
      nxt();
    end

    // M1 read behind a 3-cycle stalled M0 write
    do_reset();
    set_m0(1'b1, 24'h40, HTRANS_NONSEQ, 1'b1);
    #1;
    check("t4_m0_addr", 32'(s_haddr), 32'h40);
    nxt();
    set_m0(1'b0, 24'h0, HTRANS_IDLE, 1'b0);
    m0_hwdata = 32'h55;
    s_hreadyout = 1'b0;
    set_m1(1'b1, 24'h80, HTRANS_NONSEQ, 1'b0);
    #1;
    check("t4_m0rdy_s1", 32'(m0_hready), 32'h0);
    check("t4_m1rdy_s1", 32'(m1_hready), 32'h1);
    check("t4_hsel_s1", 32'(s_hsel), 32'h0);
    nxt();
    set_m1(1'b0, 24'h0, HTRANS_IDLE, 1'b0);
    #1;
    check("t4_m1rdy_s2", 32'(m1_hready), 32'h0);
    nxt();
    #1;
    check("t4_m1rdy_s3", 32'(m1_hready), 32'h0);
    check("t4_m0rdy_s3", 32'(m0_hready), 32'h0);
    nxt();
    s_hreadyout = 1'b1;
    #1;
    check("t4_m1_addr", 32'(s_haddr), 32'h80);
    check("t4_m1_hsel", 32'(s_hsel), 32'h1);
    check("t4_m1_write", 32'(s_hwrite), 32'h0);
    check("t4_m0rdy_end", 32'(m0_hready), 32'h1);
    check("t4_m1rdy_gnt", 32'(m1_hready), 32'h0);
    check("t4_wdata", s_hwdata, 32'h55);
    nxt();
    s_hrdata = 32'h0000000F;
    #1;
    check("t4_m1rdata", m1_hrdata, 32'h0000000F);
    check("t4_m1rdy_dp", 32'(m1_hready), 32'h1);
    check("t4_m0rdata", m0_hrdata, 32'h0);
    nxt();

    // ERROR to M0 while M1 write is pending
    do_reset();
    set_m0(1'b1, 24'h60, HTRANS_NONSEQ, 1'b0);
    nxt();
    set_m0(1'b0, 24'h0, HTRANS_IDLE, 1'b0);
    set_m1(1'b1, 24'h70, HTRANS_NONSEQ, 1'b1);
    s_hresp = HRESP_ERROR;
    s_hreadyout = 1'b0;
    #1;
    check("t5_m0resp1", 32'(m0_hresp), 32'h1);
    check("t5_m0rdy1", 32'(m0_hready), 32'h0);
    check("t5_m1resp1", 32'(m1_hresp), 32'h0);
    nxt();
    set_m1(1'b0, 24'h0, HTRANS_IDLE, 1'b0);
    s_hreadyout = 1'b1;
    #1;
    check("t5_m0resp2", 32'(m0_hresp), 32'h1);
    check("t5_m0rdy2", 32'(m0_hready), 32'h1);
    check("t5_m1_addr", 32'(s_haddr), 32'h70);
    check("t5_m1_write", 32'(s_hwrite), 32'h1);
    check("t5_m1rdy2", 32'(m1_hready), 32'h0);
    nxt();
    s_hresp = HRESP_OKAY;
    m1_hwdata = 32'hBEEF;
    #1;
    check("t5_wdata", s_hwdata, 32'hBEEF);
    check("t5_m1resp3", 32'(m1_hresp), 32'h0);
    check("t5_m1rdy3", 32'(m1_hready), 32'h1);
    nxt();
    check("t5_latched", sl_wdata, 32'hBEEF);

    // Reset mid-transfer with M1 pending
    do_reset();
    set_m0(1'b1, 24'h10, HTRANS_NONSEQ, 1'b0);
    set_m1(1'b1, 24'h20, HTRANS_NONSEQ, 1'b0);
    nxt();
    idle_all();
    s_hreadyout = 1'b0;
    s_hrdata = 32'h77;
    #1;
    check("t6_m1_pend", 32'(m1_hready), 32'h0);
    #1 HRESETn = 1'b0;
    #1;
    check("t6_shsel", 32'(s_hsel), 32'h0);
    check("t6_shtrans", 32'(s_htrans), 32'h0);
    check("t6_shaddr", 32'(s_haddr), 32'h0);
    check("t6_shwrite", 32'(s_hwrite), 32'h0);
    check("t6_shsize", 32'(s_hsize), 32'h0);
    check("t6_m0rdy", 32'(m0_hready), 32'h1);
    check("t6_m1rdy", 32'(m1_hready), 32'h1);
    check("t6_m0resp", 32'(m0_hresp), 32'h0);
    check("t6_m0rdata", m0_hrdata, 32'h0);
    s_hreadyout = 1'b1;
    snap = n_xfer;
    nxt();
    HRESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t6_quiet", 32'(s_hsel), 32'h0);
      nxt();
    end
    check("t6_no_replay", 32'(n_xfer), 32'(snap));
    set_m1(1'b1, 24'h300, HTRANS_NONSEQ, 1'b0);
    #1;
    check("t6_new_hsel", 32'(s_hsel), 32'h1);
    check("t6_new_addr", 32'(s_haddr), 32'h300);
    nxt();
    idle_all();
    #1;
    check("t6_new_xfer", 32'(n_xfer), 32'(snap + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
